// File: rtl/arbiter8.sv
// Round-robin arbiter for 8 requesters with optional hold-time preemption.
// The one-hot grant is decoded from the registered grantee index.

module decoder38 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);
  assign dec = 8'b0000_0001 << sel;
endmodule

module arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] idx,
  output logic       vld
);

  localparam int CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  // Counter stops here: the preemption threshold, or all-ones when preemption is off
  localparam logic [CNT_W-1:0] CNT_SAT = (HOLD_MAX == 0) ? {CNT_W{1'b1}}
                                                         : CNT_W'(HOLD_MAX - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic [2:0]       idx_nx;
  logic [2:0]       last, last_nx;
  logic             vld_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       dec;
  logic [2:0]       winner;
  logic             release_c;

  // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    dbl = {r, r} >> start;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    return start + off;
  endfunction

  decoder38 u_dec (
    .sel (idx),
    .dec (dec)
  );

  assign gnt    = vld ? dec : 8'h00;
  assign winner = rr_pick(req, last + 3'd1);

  assign release_c = !req[idx] ||
                     ((HOLD_MAX != 0) && (cnt == CNT_SAT) && ((req & ~gnt) != 8'h00));

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    vld_nx   = vld;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req != 8'h00) begin
          idx_nx   = winner;
          vld_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (release_c) begin
          vld_nx   = 1'b0;
          last_nx  = idx;
          state_nx = IDLE;
        end else if (cnt != CNT_SAT) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      vld   <= 1'b0;
      last  <= 3'd7;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      vld   <= vld_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_arbiter8.sv
// Bench for arbiter8 (HOLD_MAX=4): vector table, directed corner sequences,
// and random requests compared against a cycle-level round-robin model.

module tb_arbiter8;

  localparam int HM = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] idx;
  logic       vld;

  int n_chk;
  int n_err;

  // Reference model state: who holds the grant and for how many cycles so far
  bit m_vld;
  int m_idx;
  int m_last;
  int m_hold;

  typedef struct packed {
    logic [7:0] req;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] gnt;
  } vec_t;

  vec_t tbl[$];

  arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .idx   (idx),
    .vld   (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_idx  = 0;
    m_last = 7;
    m_hold = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit found;
    bit others;
    if (!m_vld) begin
      if (r != 8'h00) begin
        found = 1'b0;
        for (int j = 1; j <= 8; j++) begin
          if (!found && r[(m_last + j) % 8]) begin
            m_idx = (m_last + j) % 8;
            found = 1'b1;
          end
        end
        m_vld  = 1'b1;
        m_hold = 1;
      end
    end else begin
      others = (r & ~(8'h01 << m_idx)) != 8'h00;
      if (!r[m_idx] || (HM > 0 && m_hold >= HM && others)) begin
        m_vld  = 1'b0;
        m_last = m_idx;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [7:0] eg;
    eg = m_vld ? (8'h01 << m_idx) : 8'h00;
    check({name, "_gnt"}, gnt, eg);
    check({name, "_vld"}, {7'd0, vld}, {7'd0, m_vld});
    if (m_vld) check({name, "_idx"}, {5'd0, idx}, 8'(m_idx));
  endtask

  // Drive req, let one rising edge sample it, then look at outputs 1ns later
  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ev, input logic [2:0] ei,
                            input logic [7:0] eg);
    check({name, "_gnt"}, gnt, eg);
    check({name, "_vld"}, {7'd0, vld}, {7'd0, ev});
    if (ev) check({name, "_idx"}, {5'd0, idx}, {5'd0, ei});
  endtask

  initial begin
    logic [7:0] r;
    logic [2:0] g;
    n_chk = 0;
    n_err = 0;
    model_reset();

    // Rotation vectors: req=FF, each grant lasts HM cycles then one dead cycle
    for (int k = 0; k < 9; k++) begin
      g = 3'(k % 8);
      for (int c = 0; c < HM; c++) tbl.push_back({8'hFF, 1'b1, g, 8'h01 << g});
      tbl.push_back({8'hFF, 1'b0, 3'd0, 8'h00});
    end

    // Reset held with all requests asserted
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_vld", {7'd0, vld}, 8'h00);
    check("rst_idx", {5'd0, idx}, 8'h00);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].req);
      expect_out($sformatf("rot%0d", i), tbl[i].vld, tbl[i].idx, tbl[i].gnt);
    end

    // Sparse/wrap: establish last=5, then req 5 and 0 -> 0 first, 5 after preemption
    cycle(8'h20); expect_out("sp_g5", 1'b1, 3'd5, 8'h20);
    cycle(8'h00); expect_out("sp_rel", 1'b0, 3'd0, 8'h00);
    cycle(8'h21); expect_out("sp_wrap0", 1'b1, 3'd0, 8'h01);
    for (int c = 1; c < HM; c++) begin
      cycle(8'h21); expect_out("sp_hold0", 1'b1, 3'd0, 8'h01);
    end
    cycle(8'h21); expect_out("sp_dead", 1'b0, 3'd0, 8'h00);
    cycle(8'h21); expect_out("sp_then5", 1'b1, 3'd5, 8'h20);
    cycle(8'h00); expect_out("sp_end", 1'b0, 3'd0, 8'h00);

    // Lone requester is never preempted
    for (int c = 0; c < 40; c++) begin
      cycle(8'h08); expect_out($sformatf("hold%0d", c), 1'b1, 3'd3, 8'h08);
    end
    cycle(8'h00); expect_out("hold_drop", 1'b0, 3'd0, 8'h00);

    // Single-cycle pulse gets exactly one grant cycle
    cycle(8'h40); expect_out("pulse_on", 1'b1, 3'd6, 8'h40);
    cycle(8'h00); expect_out("pulse_off", 1'b0, 3'd0, 8'h00);
    cycle(8'h00); expect_out("pulse_idle", 1'b0, 3'd0, 8'h00);

    // Holder drops while requester 2 waits: one dead cycle, then 2
    cycle(8'h02); expect_out("drop_g1", 1'b1, 3'd1, 8'h02);
    cycle(8'h04); expect_out("drop_dead", 1'b0, 3'd0, 8'h00);
    cycle(8'h04); expect_out("drop_g2", 1'b1, 3'd2, 8'h04);
    cycle(8'h00); expect_out("drop_end", 1'b0, 3'd0, 8'h00);

    // Asynchronous reset in the middle of a grant
    cycle(8'h40); expect_out("mid_g6", 1'b1, 3'd6, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 8'h00);
    check("async_vld", {7'd0, vld}, 8'h00);
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle(8'h40); expect_out("after_rst_g6", 1'b1, 3'd6, 8'h40);
    cycle(8'h00); expect_out("after_rst_rel", 1'b0, 3'd0, 8'h00);
    // last was 6 after release; with 7 and 0 both asking, 7 comes first
    cycle(8'h81); expect_out("after_rst_g7", 1'b1, 3'd7, 8'h80);
    cycle(8'h00);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'h01 << $urandom_range(0, 7);
        2: r = 8'($urandom) & 8'($urandom);
        default: r = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) < 6 && m_vld) r[m_idx] = 1'b1;
      cycle(r);
      check_model($sformatf("rnd%0d", c));
      check($sformatf("rnd%0d_onehot", c), 8'($countones(gnt) <= 1), 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arbiter8.md
# arbiter8

Round-robin arbiter for up to 8 requesters sharing one resource. Each cycle it picks the next requester after the last one served and holds the grant while that requester keeps asking. The grant is presented both as a 3-bit index and as a one-hot vector. The one-hot vector is produced by feeding the registered index into the team's existing 3-to-8 decoder (decoder38). The block sits between requesting units and any shared bus or port, and its `gnt` lines drive that resource's select/enable inputs.

## Interface
- HOLD_MAX, 15: maximum consecutive cycles one requester may hold the grant while others are waiting; 0 disables preemption. Range 0..255.
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  request vector, bit i = requester i; level-sensitive
- gnt  output  8  one-hot grant, all zero when no grant is active
- idx  output  3  index of the current grantee; valid only when vld=1
- vld  output  1  a grant is active

## Operation
- State machine: IDLE, BUSY.
- Registers:
  - state
  - idx (3b)
  - vld
  - last: 3b index of the most recent grantee
  - cnt: hold counter, width clog2(HOLD_MAX+1), minimum 1
- Search order: start at (last+1) mod 8, ascending, wrapping 7→0. The first set `req` bit wins. Implemented as a rotate, priority-encode, then add `last+1` mod 8.
- IDLE:
  - If req != 0: idx <= winner, vld <= 1, cnt <= 0, state <= BUSY.
  - Otherwise stay in IDLE, vld = 0.
- BUSY, release condition (either is sufficient):
  - req[idx] = 0.
  - HOLD_MAX != 0, cnt == HOLD_MAX-1, and (req & ~gnt) != 0.
- BUSY, on release: vld <= 0, last <= idx, state <= IDLE. idx keeps its value but is meaningless while vld = 0.
- BUSY, otherwise: cnt <= cnt+1, saturating at HOLD_MAX-1 (or at the counter maximum when HOLD_MAX = 0).
- A lone requester past HOLD_MAX is never preempted: cnt saturates and the grant is kept.
- Changes on non-grantee `req` bits during BUSY have no effect except enabling preemption.
- gnt = vld ? decoder38(idx) : 8'h00. This is combinational from registered idx/vld, so gnt has no path from req.
- Reset (asynchronous, any time including mid-grant):
  - state = IDLE, vld = 0, gnt = 8'h00, idx = 0, cnt = 0.
  - last = 7, so the first search after reset starts at requester 0.

## Timing
- Grant latency: req sampled at edge N gives vld/gnt/idx valid after edge N. The response is one cycle, registered.
- A single-cycle req pulse in IDLE is still granted. Because req[idx] is then 0, the grant releases at the next edge, giving exactly 1 grant cycle.
- Release: the condition is seen in cycle k and gnt = 0 from edge k+1.
- One mandatory dead cycle (vld=0) between consecutive grants. Back-to-back throughput is therefore one grant per 2 cycles minimum.
- Preemption: with others waiting, a grant lasts exactly HOLD_MAX cycles (cnt = 0..HOLD_MAX-1).
- Simultaneous events: if the grantee drops req in the same cycle the counter expires, this is a normal release. last is updated identically in both cases.
- gnt is always one-hot or zero, never multi-hot, including during and after reset.

## Test plan
- **Reset:** hold rst_n=0 with req=8'hFF → gnt=8'h00, vld=0, idx=0. Release rst_n → one cycle later idx=0, gnt=8'h01.
- **Rotation:** req=8'hFF held constant, HOLD_MAX=4 → successive grants idx 0,1,2,…,7,0. Each grant lasts 4 cycles with one vld=0 cycle between grants. Confirms wrap 7→0.
- **Sparse/wrap:** last=5, req=8'b0010_0001 → next grant idx=0 (skips 6,7, wraps). Then with req unchanged, the following grant is idx=5.
- **Hold without contention:** req=8'h08 for 40 cycles, HOLD_MAX=4 → idx=3, gnt=8'h08 continuously for 40 cycles with no preemption. Drop req → gnt=8'h00 next cycle.
- **Pulse and release:**
  - 1-cycle req=8'h40 in IDLE → gnt=8'h40 for exactly 1 cycle.
  - Holder drops req while req[2] is high → 1 dead cycle, then gnt=8'h04.
- **Reset mid-grant:** grant active at idx=6, assert rst_n=0 asynchronously between edges → gnt=8'h00 and vld=0 immediately (before the next clk edge). After release with req=8'h40 → idx=6 granted, last restarted at 7.
